// File: rtl/rshift_pkg.sv
// Shared constants and helpers for the serial capture path (rshift_capture and friends).
package rshift_pkg;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/rshift_if.sv
// Serial input, output-buffer handshake and status bundle of the capture block.
interface rshift_if #(
    parameter int WIDTH = rshift_pkg::DEFAULT_WIDTH
) ();
    import rshift_pkg::*;

    localparam int CNT_W = cnt_width(WIDTH);

    logic             sin;
    logic             sin_valid;
    logic             abort;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic [CNT_W-1:0] bit_cnt;
    logic             overrun;
    logic             clr_err;

    modport master (
        output sin, sin_valid, abort, data_ready, clr_err,
        input  data_out, data_valid, bit_cnt, overrun
    );

    modport slave (
        input  sin, sin_valid, abort, data_ready, clr_err,
        output data_out, data_valid, bit_cnt, overrun
    );

endinterface

// File: rtl/rshift_core.sv
// Shift register and bit counter; flags the cycle in which a word completes and
// presents that word (the next shift-register value) alongside it.
module rshift_core #(
    parameter int WIDTH     = rshift_pkg::DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = rshift_pkg::cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             abort,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             complete,
    output logic [WIDTH-1:0] word
);
    import rshift_pkg::*;

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic             last_bit;

    always_comb begin
        sreg_next = MSB_FIRST ? {sreg[WIDTH-2:0], sin} : {sin, sreg[WIDTH-1:1]};
        last_bit  = (bit_cnt == CNT_W'(WIDTH - 1));
        complete  = sin_valid && !abort && last_bit;
        word      = sreg_next;
    end

    // Abort takes priority over a bit arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (abort) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (sin_valid) begin
            sreg    <= sreg_next;
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rshift_capture.sv
// Serial-in/parallel-out receiver: assembles words in rshift_core and hands them
// downstream through a one-entry valid/ready buffer with sticky overrun flag.
module rshift_capture #(
    parameter int WIDTH     = rshift_pkg::DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    rshift_if.slave  bus
);
    import rshift_pkg::*;

    localparam int CNT_W = cnt_width(WIDTH);

    logic [CNT_W-1:0] bit_cnt;
    logic             complete;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             overrun;
    logic             buf_free;

    rshift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .CNT_W     (CNT_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .sin       (bus.sin),
        .sin_valid (bus.sin_valid),
        .abort     (bus.abort),
        .bit_cnt   (bit_cnt),
        .complete  (complete),
        .word      (word)
    );

    // The buffer can take a new word if empty or being drained this very edge.
    assign buf_free = !data_valid || bus.data_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (complete && buf_free) begin
                data_out   <= word;
                data_valid <= 1'b1;
            end else if (data_valid && bus.data_ready) begin
                data_valid <= 1'b0;
            end

            if (complete && !buf_free) begin
                overrun <= 1'b1;
            end else if (bus.clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    assign bus.data_out   = data_out;
    assign bus.data_valid = data_valid;
    assign bus.bit_cnt    = bit_cnt;
    assign bus.overrun    = overrun;

endmodule
